mem_op_ingress: RTL and testbench

Front end of the DDR memory-model FSM. It merges fresh ring requests and re-issued reads from the resend queue into one in-order memory-op queue. It also packs the 32-bit flush data words from the ring into 128-bit beats in the write-data queue. Its outputs drive the FSM's `memOpQempty/rdMemOp/memOpDest/memOpData` and `writeDataQempty/rdWriteData/writeDataIn` ports directly.

---
 rtl/mem_op_ingress.sv | 175 +++++++++++++++++
 tb/tb_mem_op_ingress.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_op_ingress.sv
// Ingress front end for the DDR memory-model FSM: merges ring requests and resends
// into one memory-op queue, and packs 32-bit flush words into 128-bit write beats.

module mem_op_ingress_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  // Fall-through head; stale storage is masked so an empty queue reads as zero.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

module mem_op_ingress #(
  parameter int MOQ_DEPTH = 16,
  parameter int WDQ_DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqValid,
  input  logic [3:0]   reqDest,
  input  logic [31:0]  reqData,
  output logic         reqAccept,
  input  logic         wdValid,
  input  logic [31:0]  wdWord,
  output logic         wdAccept,
  input  logic         resendValid,
  input  logic [39:0]  resendIn,
  output logic         rdResend,
  output logic         memOpQempty,
  input  logic         rdMemOp,
  output logic [3:0]   memOpDest,
  output logic [31:0]  memOpData,
  output logic         writeDataQempty,
  input  logic         rdWriteData,
  output logic [127:0] writeDataIn
);
  localparam int MAW = $clog2(MOQ_DEPTH);
  localparam int WAW = $clog2(WDQ_DEPTH);
  localparam logic [WAW:0] WDQ_RES_LIMIT = (WAW+1)'(WDQ_DEPTH - 2);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    word_cnt_q, word_cnt_d;
  logic [95:0]   pack_q, pack_d;

  logic          moq_full, moq_push;
  logic [35:0]   moq_push_data, moq_head;
  logic [MAW:0]  moq_count_unused;
  logic          wdq_full, wdq_push;
  logic [WAW:0]  wdq_count;
  logic          unused_resend_type;

  assign unused_resend_type = ^resendIn[35:32];

  // Resend wins the MOQ slot; a flush needs two WDQ beats reserved before acceptance.
  assign rdResend  = resendValid & ~moq_full;
  assign reqAccept = (state_q == IDLE) & ~resendValid & ~moq_full & (wdq_count <= WDQ_RES_LIMIT);
  assign wdAccept  = (state_q == COLLECT);

  assign moq_push      = rdResend | (reqValid & reqAccept);
  assign moq_push_data = rdResend ? {resendIn[39:36], resendIn[31:0]} : {reqDest, reqData};

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pack_d     = pack_q;
    wdq_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid && reqAccept && !reqData[28]) begin
          state_d    = COLLECT;
          word_cnt_d = 3'd0;
        end
      end
      COLLECT: begin
        if (wdValid) begin
          word_cnt_d = word_cnt_q + 3'd1;
          for (int l = 0; l < 3; l++) begin
            if (word_cnt_q[1:0] == 2'(l)) pack_d[l*32 +: 32] = wdWord;
          end
          if (word_cnt_q[1:0] == 2'd3) wdq_push = 1'b1;
          if (word_cnt_q == 3'd7)      state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_cnt_q <= 3'd0;
      pack_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      pack_q     <= pack_d;
    end
  end

  mem_op_ingress_fifo #(.DEPTH(MOQ_DEPTH), .WIDTH(36)) u_moq (
    .clock       (clock),
    .reset       (reset),
    .push_i      (moq_push),
    .push_data_i (moq_push_data),
    .pop_i       (rdMemOp),
    .empty_o     (memOpQempty),
    .full_o      (moq_full),
    .count_o     (moq_count_unused),
    .head_o      (moq_head)
  );

  mem_op_ingress_fifo #(.DEPTH(WDQ_DEPTH), .WIDTH(128)) u_wdq (
    .clock       (clock),
    .reset       (reset),
    .push_i      (wdq_push),
    .push_data_i ({wdWord, pack_q}),
    .pop_i       (rdWriteData),
    .empty_o     (writeDataQempty),
    .full_o      (wdq_full),
    .count_o     (wdq_count),
    .head_o      (writeDataIn)
  );

  assign memOpDest = moq_head[35:32];
  assign memOpData = moq_head[31:0];

  logic unused_wdq_full;
  assign unused_wdq_full = wdq_full;
endmodule

// File: tb/tb_mem_op_ingress.sv
// Directed bench for mem_op_ingress: table-driven read/flush sequence plus
// hand-written sequences for arbitration, queue-full, reservation and reset.

module tb_mem_op_ingress;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         reqValid = 1'b0;
  logic [3:0]   reqDest = '0;
  logic [31:0]  reqData = '0;
  logic         reqAccept;
  logic         wdValid = 1'b0;
  logic [31:0]  wdWord = '0;
  logic         wdAccept;
  logic         resendValid = 1'b0;
  logic [39:0]  resendIn = '0;
  logic         rdResend;
  logic         memOpQempty;
  logic         rdMemOp = 1'b0;
  logic [3:0]   memOpDest;
  logic [31:0]  memOpData;
  logic         writeDataQempty;
  logic         rdWriteData = 1'b0;
  logic [127:0] writeDataIn;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_op_ingress #(.MOQ_DEPTH(16), .WDQ_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqDest(reqDest), .reqData(reqData), .reqAccept(reqAccept),
    .wdValid(wdValid), .wdWord(wdWord), .wdAccept(wdAccept),
    .resendValid(resendValid), .resendIn(resendIn), .rdResend(rdResend),
    .memOpQempty(memOpQempty), .rdMemOp(rdMemOp), .memOpDest(memOpDest), .memOpData(memOpData),
    .writeDataQempty(writeDataQempty), .rdWriteData(rdWriteData), .writeDataIn(writeDataIn)
  );

  typedef struct {
    logic        req_v;
    logic [3:0]  req_dest;
    logic [31:0] req_data;
    logic        wd_v;
    logic [31:0] wd_word;
    logic        rd_moq;
    logic        e_req_acc;
    logic        e_wd_acc;
    logic        e_moq_empty;
    logic [35:0] e_moq_head;
    logic        e_wdq_empty;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_flush(input logic [3:0] d, input logic [31:0] addr, input logic [31:0] base);
    reqValid = 1'b1; reqDest = d; reqData = addr;
    settle();
    check("flush_req_accept", {127'b0, reqAccept}, 128'd1);
    tick();
    reqValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wdValid = 1'b1; wdWord = base + 32'(k);
      tick();
    end
    wdValid = 1'b0;
    $display("flush dest=%0d addr=%h words %h..%h", d, addr, base, base + 32'd7);
  endtask

  initial begin
    // Read then flush; early word and a mid-COLLECT request must both be held off.
    vecs[0] = '{1, 4'd2, 32'h1000_0040, 1, 32'hDEAD_BEEF, 0, 1, 0, 1, 36'h0, 1};
    vecs[1] = '{1, 4'd2, 32'h0000_0080, 0, 32'h0, 0, 1, 0, 0, {4'd2, 32'h1000_0040}, 1};
    for (int k = 0; k < 8; k++)
      vecs[2+k] = '{(k == 1), 4'd9, 32'h1000_0999, 1, 32'(k), 0, 0, 1, 0,
                    {4'd2, 32'h1000_0040}, (k < 4)};
    vecs[10] = '{0, 4'd0, 32'h0, 0, 32'h0, 1, 1, 0, 0, {4'd2, 32'h1000_0040}, 0};
    vecs[11] = '{0, 4'd0, 32'h0, 0, 32'h0, 1, 1, 0, 0, {4'd2, 32'h0000_0080}, 0};

    #1 reset = 1'b0;
    #2;
    check("rst_moq_empty", {127'b0, memOpQempty}, 128'd1);
    check("rst_wdq_empty", {127'b0, writeDataQempty}, 128'd1);
    check("rst_head", {92'b0, memOpDest, memOpData}, 128'd0);
    check("rst_wdata", writeDataIn, 128'd0);
    check("rst_wd_accept", {127'b0, wdAccept}, 128'd0);
    check("rst_rd_resend", {127'b0, rdResend}, 128'd0);
    check("rst_req_accept", {127'b0, reqAccept}, 128'd1);
    #9 reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      reqValid = vecs[i].req_v; reqDest = vecs[i].req_dest; reqData = vecs[i].req_data;
      wdValid = vecs[i].wd_v; wdWord = vecs[i].wd_word; rdMemOp = vecs[i].rd_moq;
      settle();
      $display("vec %0d acc=%b wda=%b moqE=%b head=%h wdqE=%b", i, reqAccept, wdAccept,
               memOpQempty, {memOpDest, memOpData}, writeDataQempty);
      check($sformatf("vec%0d_req_accept", i), {127'b0, reqAccept}, {127'b0, vecs[i].e_req_acc});
      check($sformatf("vec%0d_wd_accept", i), {127'b0, wdAccept}, {127'b0, vecs[i].e_wd_acc});
      check($sformatf("vec%0d_moq_empty", i), {127'b0, memOpQempty}, {127'b0, vecs[i].e_moq_empty});
      check($sformatf("vec%0d_moq_head", i), {92'b0, memOpDest, memOpData}, {92'b0, vecs[i].e_moq_head});
      check($sformatf("vec%0d_wdq_empty", i), {127'b0, writeDataQempty}, {127'b0, vecs[i].e_wdq_empty});
      tick();
    end
    reqValid = 0; wdValid = 0; rdMemOp = 0;
    settle();
    check("moq_drained", {127'b0, memOpQempty}, 128'd1);
    check("beat0", writeDataIn, 128'h00000003_00000002_00000001_00000000);
    rdWriteData = 1; tick();
    check("beat1", writeDataIn, 128'h00000007_00000006_00000005_00000004);
    tick(); rdWriteData = 0;
    settle();
    check("wdq_drained", {127'b0, writeDataQempty}, 128'd1);
    check("wdq_empty_data", writeDataIn, 128'd0);

    // Simultaneous resend and ring request.
    resendValid = 1; resendIn = {4'h5, 4'hF, 32'hAAAA_0001};
    reqValid = 1; reqDest = 4'd3; reqData = 32'h1000_0100;
    settle();
    check("sim_rd_resend", {127'b0, rdResend}, 128'd1);
    check("sim_req_accept", {127'b0, reqAccept}, 128'd0);
    tick();
    resendValid = 0;
    settle();
    check("sim_req_accept_next", {127'b0, reqAccept}, 128'd1);
    tick();
    reqValid = 0;
    settle();
    check("sim_head0", {92'b0, memOpDest, memOpData}, {92'b0, 4'h5, 32'hAAAA_0001});
    rdMemOp = 1; tick();
    check("sim_head1", {92'b0, memOpDest, memOpData}, {92'b0, 4'h3, 32'h1000_0100});
    tick(); rdMemOp = 0;
    settle();
    check("sim_drained", {127'b0, memOpQempty}, 128'd1);
    $display("simultaneous sources done");

    // MOQ full: 16 reads, then one pop admits exactly one resend.
    for (int i = 0; i < 16; i++) begin
      reqValid = 1; reqDest = 4'h7; reqData = 32'h1000_0000 + 32'(i);
      tick();
    end
    reqData = 32'h1000_FFFF;
    settle();
    check("full_req_accept", {127'b0, reqAccept}, 128'd0);
    reqValid = 0;
    resendValid = 1; resendIn = {4'hC, 4'h0, 32'hC0FF_EE00};
    rdMemOp = 1;
    settle();
    check("full_rd_resend", {127'b0, rdResend}, 128'd0);
    tick();
    rdMemOp = 0;
    settle();
    check("full_after_pop_rd_resend", {127'b0, rdResend}, 128'd1);
    tick();
    resendValid = 0;
    settle();
    check("full_again_req_accept", {127'b0, reqAccept}, 128'd0);
    resendValid = 1;
    #1;
    check("full_again_rd_resend", {127'b0, rdResend}, 128'd0);
    resendValid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 15)
        check($sformatf("full_drain%0d", i), {92'b0, memOpDest, memOpData},
              {92'b0, 4'h7, 32'h1000_0001 + 32'(i)});
      else
        check("full_drain_resend", {92'b0, memOpDest, memOpData}, {92'b0, 4'hC, 32'hC0FF_EE00});
      rdMemOp = 1; tick();
    end
    rdMemOp = 0;
    settle();
    check("full_drained", {127'b0, memOpQempty}, 128'd1);
    $display("moq full sequence done");

    // WDQ reservation: eight flushes fill 16 beats, pop one leaves 15.
    for (int f = 0; f < 8; f++)
      do_flush(4'(f), 32'h100 * 32'(f), 32'(f * 16));
    rdWriteData = 1; tick(); rdWriteData = 0;
    settle();
    check("res_head_beat", writeDataIn, 128'h00000007_00000006_00000005_00000004);
    reqValid = 1; reqDest = 4'hA; reqData = 32'h0000_0A00;
    check("res_wdq15_accept", {127'b0, reqAccept}, 128'd0);
    tick();
    check("res_wdq15_accept_hold", {127'b0, reqAccept}, 128'd0);
    rdWriteData = 1;
    #1;
    check("res_pop_cycle_accept", {127'b0, reqAccept}, 128'd0);
    tick();
    rdWriteData = 0;
    settle();
    check("res_wdq14_accept", {127'b0, reqAccept}, 128'd1);
    tick();
    reqValid = 0;
    for (int k = 0; k < 5; k++) begin
      wdValid = 1; wdWord = 32'hF000_0000 + 32'(k);
      tick();
    end
    wdValid = 0;
    check("collect_wd_accept", {127'b0, wdAccept}, 128'd1);
    check("collect_moq_nonempty", {127'b0, memOpQempty}, 128'd0);

    // Async reset mid-COLLECT, asserted between clock edges.
    #2 reset = 1'b0;
    #1;
    check("arst_moq_empty", {127'b0, memOpQempty}, 128'd1);
    check("arst_wdq_empty", {127'b0, writeDataQempty}, 128'd1);
    check("arst_wd_accept", {127'b0, wdAccept}, 128'd0);
    check("arst_head", {92'b0, memOpDest, memOpData}, 128'd0);
    check("arst_wdata", writeDataIn, 128'd0);
    #2 reset = 1'b1;
    tick();
    do_flush(4'd1, 32'h0000_0200, 32'h10);
    settle();
    check("post_rst_moq_head", {92'b0, memOpDest, memOpData}, {92'b0, 4'd1, 32'h0000_0200});
    check("post_rst_beat0", writeDataIn, 128'h00000013_00000012_00000011_00000010);
    rdWriteData = 1; tick(); rdWriteData = 0;
    settle();
    check("post_rst_beat1", writeDataIn, 128'h00000017_00000016_00000015_00000014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
